uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- UART receiver: the far end of the `UARTTX` link that `top` drives.
- Decodes 8N1 frames back into bytes, so the frequency-sensing readout can be checked in loopback on the bench or in a host-side FPGA.
- Presents each byte on a valid/ready handshake.
- Flags framing errors and overruns with sticky bits.

Parameters:
- CLKS_PER_BIT, 434, CLK cycles per bit (50 MHz / 115200); legal range >= 8.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- RX  in  1  serial line, idle high, asynchronous to CLK.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- err_clr  in  1  one-cycle pulse, clears frame_err and overrun.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: byte dropped because the buffer was full.
- busy  out  1  receiver not in IDLE.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST_N is asynchronous and active-low.
- Reset values:
  - Both synchronizer flops = 1; state = IDLE.
  - rx_data = 0; rx_valid, frame_err, overrun, busy = 0.
  - Bit counter, cycle counter and shift register = 0.
- Synchronizer: RX passes through 2 flops; all decisions use the second-stage output rx_s.
- Cycle counter cnt: reset to 0 on every state entry.
- State machine (IDLE, START, DATA, STOP, WAIT_HIGH):
  - IDLE: when rx_s == 0, go to START.
  - START: at cnt == CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
    - Sample 1 (glitch): return to IDLE; no flags change.
    - Sample 0: go to DATA with bit_idx = 0.
  - DATA: at cnt == CLKS_PER_BIT - 1, shift rx_s into the shift register MSB and shift right (LSB-first reception); increment bit_idx.
    - After DATA_BITS samples, go to STOP.
  - STOP: at cnt == CLKS_PER_BIT - 1, sample rx_s.
    - Sample 1: deliver the byte; go to IDLE.
    - Sample 0: set frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a break condition from restarting reception.
- Sample timing: every sample sits mid-bit, CLKS_PER_BIT/2 cycles after the synchronized falling edge plus n * CLKS_PER_BIT.
- busy = (state != IDLE), registered with the state.
- Delivery, in the cycle after the stop-sample edge:
  - rx_valid == 0, or rx_valid == 1 with rx_ready == 1 that cycle: load rx_data; rx_valid = 1.
  - rx_valid == 1 with rx_ready == 0: keep the old rx_data and rx_valid; set overrun; drop the new byte.
- Handshake:
  - Transfer occurs on any cycle with rx_valid && rx_ready.
  - rx_valid falls on the next edge unless a delivery coincides.
  - rx_data is stable while rx_valid == 1.
- err_clr: clears frame_err and overrun on the next edge. If a set event occurs in the same cycle, set wins.
- rx_ready while rx_valid == 0: ignored.
- Reset asserted mid-frame: everything returns to reset values immediately.
  - After release with RX low mid-frame, a false start may be detected.
  - The receiver then resyncs through the STOP / WAIT_HIGH path; no lockup.

Test Plan:
- Common setup: CLKS_PER_BIT = 16, 20 ns CLK.
- Clean frame: send 0x55 with rx_ready = 0.
  - rx_valid rises exactly 1 cycle after the stop sample.
  - rx_data = 0x55; frame_err = 0; overrun = 0; busy returns to 0.
- Glitch rejection: drive RX low for 4 cycles, then high.
  - No rx_valid.
  - busy high for about 8 cycles, then 0.
  - A following 0xC3 frame is received correctly.
- Framing error: send 0xA5 with the stop bit forced low for 3 bit-times, then high.
  - frame_err = 1; rx_valid stays 0.
  - The next frame 0x3C is received with rx_data = 0x3C.
  - An err_clr pulse then gives frame_err = 0.
- Overrun: send back-to-back frames 0x11 and 0x22 with rx_ready = 0.
  - rx_data = 0x11; overrun = 1.
  - A one-cycle rx_ready pulse gives rx_valid = 0 on the next edge.
- Simultaneous events:
  - err_clr in the same cycle a third byte overruns: overrun stays 1.
  - rx_ready in the same cycle as delivery of 0x7E: rx_valid stays 1 and rx_data = 0x7E.
- Reset mid-frame: assert RST_N = 0 during bit 4 of 0xF0.
  - All outputs read 0 while reset is held.
  - After release and line idle, 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1-style UART receiver with a one-entry valid/ready output
// buffer and sticky framing-error / overrun flags.
`timescale 1ns/1ps
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 RX,
   input  logic                 rx_ready,
   input  logic                 err_clr,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   rx_meta;
   logic                   rx_s;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       bit_idx;
   logic [DATA_BITS-1:0]   shreg;
   logic                   shift_en;
   logic                   deliver;
   logic                   ferr_set;
   logic                   deliver_p1;
   logic                   ovr_set;
   logic                   accept;

   // Two-flop synchronizer; the line idles high so both flops reset to 1
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   // State register; busy is registered alongside the state
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= S_IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != S_IDLE);
      end
   end

   // Next-state logic and per-cycle strobes for shifting, delivery and framing errors
   always_comb begin
      state_next = state;
      shift_en   = 1'b0;
      deliver    = 1'b0;
      ferr_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_s) state_next = S_START;
         end
         S_START: begin
            // A line already high again at mid start bit was only a glitch
            if (cnt == HALF_LAST) state_next = rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (cnt == FULL_LAST) begin
               shift_en = 1'b1;
               if (bit_idx == LAST_IDX) state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt == FULL_LAST) begin
               if (rx_s) begin
                  deliver    = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  ferr_set   = 1'b1;
                  state_next = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            // Hold off until a break releases, so it cannot look like a new start bit
            if (rx_s) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Bit-time counter, data bit index and LSB-first shift register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (state_next != state || shift_en) begin
            cnt <= '0;
         end else if (state == S_START || state == S_DATA || state == S_STOP) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (state == S_START && state_next == S_DATA) begin
            bit_idx <= '0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + IDX_W'(1);
         end
         if (shift_en) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         end
      end
   end

   // ---- stage boundary: stop-sample strobe registered into the delivery cycle ----
   assign accept  = deliver_p1 && (!rx_valid || rx_ready);
   assign ovr_set = deliver_p1 && rx_valid && !rx_ready;

   // Output buffer handshake and sticky flags; a set beats a same-cycle clear
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         deliver_p1 <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         deliver_p1 <= deliver;
         if (accept) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         frame_err <= ferr_set | (frame_err & ~err_clr);
         overrun   <= ovr_set  | (overrun   & ~err_clr);
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: table vectors, directed corner cases and a randomized
// frame-level run checked against a byte/flag buffer model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

   localparam int CPB = 16;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       ready;
   logic       clr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   // frame-level reference model state
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ferr;
   logic       m_ovr;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] low_bits;   // 0: good stop bit, else bit-times the stop is held low
      logic       ready_pulse;
      logic       clr_pulse;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ferr;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[5];

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .CLK(clk), .RST_N(rst_n), .RX(rx), .rx_ready(ready), .err_clr(clr),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, busy, 0);
      step(3);
   endtask

   task automatic poll_busy_fall(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 64) begin
         @(negedge clk);
         n++;
      end
      check({name, "_busyfall"}, busy, 0);
   endtask

   task automatic send_head(input logic [7:0] d);
      rx = 1'b0;
      step(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         step(CPB);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input int low_bits);
      send_head(d);
      if (low_bits > 0) begin
         rx = 1'b0;
         step(CPB * low_bits);
      end
      rx = 1'b1;
      step(CPB);
      wait_idle("frame");
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      step(1);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(1);
   endtask

   // Model rules: consuming empties the buffer, clearing drops both flags,
   // a good frame fills an empty buffer or else raises overrun, a bad stop raises frame_err.
   task automatic model_frame(input logic [7:0] d, input int low_bits, input logic rp, input logic cp);
      if (rp) m_valid = 1'b0;
      if (cp) begin
         m_ferr = 1'b0;
         m_ovr  = 1'b0;
      end
      if (low_bits > 0)      m_ferr = 1'b1;
      else if (!m_valid) begin
         m_valid = 1'b1;
         m_data  = d;
      end else               m_ovr = 1'b1;
   endtask

   task automatic compare_model(input string name);
      check({name, "_valid"}, rx_valid, m_valid);
      if (m_valid) check({name, "_data"}, rx_data, m_data);
      check({name, "_ferr"}, frame_err, m_ferr);
      check({name, "_ovr"}, overrun, m_ovr);
   endtask

   initial begin
      int cnt_busy;
      rst_n = 1'b0;
      rx    = 1'b1;
      ready = 1'b0;
      clr   = 1'b0;

      //                data   low  rp    cp    valid data   ferr  ovr
      vecs[0] = '{8'hA5, 2'd3, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
      vecs[1] = '{8'h3C, 2'd0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{8'h11, 2'd0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
      vecs[3] = '{8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
      vecs[4] = '{8'h5A, 2'd0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};

      // reset state
      step(4);
      check("rst_data", rx_data, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      step(5);

      // clean frame with delivery timing
      send_head(8'h55);
      rx = 1'b1;
      poll_busy_fall("clean");
      check("clean_valid_not_early", rx_valid, 0);
      @(negedge clk);
      check("clean_valid_rise", rx_valid, 1);
      check("clean_data", rx_data, 8'h55);
      check("clean_ferr", frame_err, 0);
      check("clean_ovr", overrun, 0);
      step(CPB);
      wait_idle("clean");

      // table-driven frames
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].ready_pulse) pulse_ready();
         if (vecs[i].clr_pulse) pulse_clr();
         send_frame(vecs[i].data, int'(vecs[i].low_bits));
         check($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
         check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
         check($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_ferr);
         check($sformatf("vec%0d_ovr", i), overrun, vecs[i].exp_ovr);
      end

      // a single-cycle ready pulse empties the buffer on the next edge
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      check("ready_drops_valid", rx_valid, 0);
      pulse_clr();
      check("clr_ovr", overrun, 0);

      // glitch rejection
      cnt_busy = 0;
      rx = 1'b0;
      for (int i = 0; i < 48; i++) begin
         @(posedge clk);
         #1;
         if (i == 3) rx = 1'b1;
         if (busy) cnt_busy++;
      end
      check("glitch_busy_cycles", cnt_busy, 8);
      check("glitch_no_valid", rx_valid, 0);
      check("glitch_no_ferr", frame_err, 0);
      send_frame(8'hC3, 0);
      check("after_glitch_valid", rx_valid, 1);
      check("after_glitch_data", rx_data, 8'hC3);

      // err_clr coinciding with an overrun: the set wins
      send_head(8'h99);
      rx = 1'b1;
      poll_busy_fall("ovr_clr");
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      check("ovr_clr_same_cycle", overrun, 1);
      check("ovr_clr_data_kept", rx_data, 8'hC3);
      step(CPB);
      wait_idle("ovr_clr");
      pulse_clr();

      // rx_ready coinciding with delivery of a new byte
      send_head(8'h7E);
      rx = 1'b1;
      poll_busy_fall("rdy_dlv");
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      check("rdy_dlv_valid", rx_valid, 1);
      check("rdy_dlv_data", rx_data, 8'h7E);
      check("rdy_dlv_ovr", overrun, 0);
      step(CPB);
      wait_idle("rdy_dlv");

      // randomized frames against the model
      m_valid = 1'b1;
      m_data  = 8'h7E;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      for (int i = 0; i < 30; i++) begin
         logic [7:0] d;
         logic       rp;
         logic       cp;
         int         lb;
         d  = 8'($urandom);
         rp = 1'($urandom_range(0, 1));
         cp = ($urandom_range(0, 3) == 0);
         lb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
         if (rp) pulse_ready();
         if (cp) pulse_clr();
         send_frame(d, lb);
         model_frame(d, lb, rp, cp);
         compare_model($sformatf("rnd%0d", i));
      end

      // reset asserted during bit 4 of 0xF0
      pulse_ready();
      rx = 1'b0;
      step(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b0;
         step(CPB);
      end
      rx = 1'b1;
      step(CPB / 2);
      rst_n = 1'b0;
      #2;
      check("midrst_busy", busy, 0);
      check("midrst_valid", rx_valid, 0);
      check("midrst_data", rx_data, 0);
      check("midrst_ferr", frame_err, 0);
      check("midrst_ovr", overrun, 0);
      step(5);
      check("midrst_busy_held", busy, 0);
      rst_n = 1'b1;
      step(40);
      send_frame(8'h0F, 0);
      check("postrst_valid", rx_valid, 1);
      check("postrst_data", rx_data, 8'h0F);
      check("postrst_ferr", frame_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
